// File: rtl/cnn_seq_ctrl.sv
// Convolution chain sequencer: loads the coefficient bank, streams one frame
// through the filter chain with window tagging, drains the pipeline, flags done.
module cnn_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int FN     = 3,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int NCOEF  = 30,
    parameter int DP_LAT = 2,
    localparam int AW    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_clip,
    input  logic             cfg_relu,
    input  logic [7:0]       cfg_relu_c,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic [WIDTH-1:0] coef_data,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [WIDTH-1:0] pix_data,
    output logic             dp_en,
    output logic [WIDTH-1:0] dp_x,
    output logic             clip,
    output logic             relu,
    output logic [7:0]       relu_c,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW = $clog2(DP_LAT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [AW-1:0]     coef_idx;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DW-1:0]     drain_cnt;
    logic [DP_LAT-1:0] tag_pipe;
    logic [DP_LAT-1:0] last_pipe;
    logic              dp_en_q;
    logic              col_end;
    logic              row_end;
    logic              tag_in;
    logic              last_in;

    assign coef_ready = (state == S_LOAD);
    assign pix_ready  = (state == S_RUN);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign dp_en      = (pix_valid & pix_ready) | (state == S_DRAIN);
    assign dp_x       = pix_ready ? pix_data : '0;

    assign col_end = (col == CW'(IMG_W - 1));
    assign row_end = (row == RW'(IMG_H - 1));
    // Only real pixels can open a window; drain bubbles always carry tag 0.
    assign tag_in  = pix_ready && (int'(row) >= FN - 1) && (int'(col) >= FN - 1);
    assign last_in = tag_in && col_end && row_end;

    assign out_valid = dp_en_q & tag_pipe[DP_LAT-1];
    assign out_last  = dp_en_q & last_pipe[DP_LAT-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            coef_idx  <= '0;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            tag_pipe  <= '0;
            last_pipe <= '0;
            dp_en_q   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            clip      <= 1'b0;
            relu      <= 1'b0;
            relu_c    <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            coef_idx  <= '0;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            tag_pipe  <= '0;
            last_pipe <= '0;
            dp_en_q   <= 1'b0;
            wr_en     <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            dp_en_q <= dp_en;
            if (dp_en) begin
                tag_pipe[0]  <= tag_in;
                last_pipe[0] <= last_in;
                for (int unsigned i = 1; i < DP_LAT; i++) begin
                    tag_pipe[i]  <= tag_pipe[i-1];
                    last_pipe[i] <= last_pipe[i-1];
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        clip      <= cfg_clip;
                        relu      <= cfg_relu;
                        relu_c    <= cfg_relu_c;
                        coef_idx  <= '0;
                        col       <= '0;
                        row       <= '0;
                        drain_cnt <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (coef_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= coef_idx;
                        wr_data <= coef_data;
                        if (coef_idx == AW'(NCOEF - 1)) begin
                            coef_idx <= '0;
                            state    <= S_RUN;
                        end else begin
                            coef_idx <= coef_idx + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (dp_en) begin
                        if (col_end) begin
                            col <= '0;
                            if (row_end) begin
                                row       <= '0;
                                drain_cnt <= '0;
                                state     <= S_DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(DP_LAT - 1)) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Directed bench for cnn_seq_ctrl on a 4x4 frame, 3x3 kernel, 10 coefficients,
// chain latency 2; bank writes and window results are checked via scoreboards.
module tb_cnn_seq_ctrl;

    localparam int WIDTH  = 16;
    localparam int FN     = 3;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int NCOEF  = 10;
    localparam int DP_LAT = 2;
    localparam int AW     = 4;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int GAP    = 3;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cfg_clip = 1'b0;
    logic             cfg_relu = 1'b0;
    logic [7:0]       cfg_relu_c = '0;
    logic             coef_valid = 1'b0;
    logic             coef_ready;
    logic [WIDTH-1:0] coef_data = '0;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [WIDTH-1:0] pix_data = '0;
    logic             dp_en;
    logic [WIDTH-1:0] dp_x;
    logic             clip;
    logic             relu;
    logic [7:0]       relu_c;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             done;

    cnn_seq_ctrl #(
        .WIDTH(WIDTH), .FN(FN), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .NCOEF(NCOEF), .DP_LAT(DP_LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .cfg_clip(cfg_clip), .cfg_relu(cfg_relu), .cfg_relu_c(cfg_relu_c),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .dp_en(dp_en), .dp_x(dp_x), .clip(clip), .relu(relu), .relu_c(relu_c),
        .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; bit last; } out_t;

    wr_t  wr_q[$];
    out_t out_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_done = -1;
    int   exp_run = -1;
    int   done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prune_out(input int from_cyc);
        for (int i = out_q.size() - 1; i >= 0; i--)
            if (out_q[i].cyc >= from_cyc) out_q.delete(i);
    endtask

    task automatic run_frame(input bit coef_gap, input int gap_at, input int abort_at,
                             input bit poke, input bit rst_drain, input logic [7:0] rc);
        int s, c, ci, pi, gap_left, abort_cyc, last_acc, done0;
        bit finished, poked;
        ci = 0; pi = 0; gap_left = 0; abort_cyc = -1; last_acc = -1;
        finished = 0; poked = 0; done0 = done_seen;
        exp_done = -1; exp_run = -1;
        @(posedge clk); #1;
        start = 1'b1; cfg_clip = rc[0]; cfg_relu = rc[1]; cfg_relu_c = rc;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0; cfg_clip = ~rc[0]; cfg_relu = ~rc[1]; cfg_relu_c = 8'h00;
        check("busy_after_start", busy, 1);
        check("relu_c_latched", relu_c, rc);
        check("clip_latched", clip, rc[0]);
        check("relu_latched", relu, rc[1]);
        for (int n = 0; n < 400 && !finished; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            c = cyc;
            start = 1'b0; abort = 1'b0; cfg_relu_c = 8'h00;
            coef_valid = (ci < NCOEF) && (!coef_gap || ((c - s) % 2 == 1));
            coef_data  = WIDTH'(16'hA000 + ci * 257);
            if (abort_cyc >= 0) begin
                pix_valid = 1'b0;
            end else if (pi == abort_at) begin
                abort = 1'b1; pix_valid = 1'b0; abort_cyc = c;
                prune_out(c + 1);
            end else if (pi == gap_at && gap_left < GAP) begin
                pix_valid = 1'b0; gap_left++;
            end else if (pi < NPIX) begin
                pix_valid = 1'b1; pix_data = WIDTH'(pi * 3 + 1);
                if (poke && !poked && pi == 5) begin
                    start = 1'b1; cfg_relu_c = 8'h55; poked = 1;
                end
            end else begin
                pix_valid = 1'b0;
            end
            #1;
            if (coef_valid && coef_ready) begin
                wr_q.push_back('{cyc: c + 1, addr: ci, data: int'(coef_data)});
                ci++;
                if (ci == NCOEF) begin
                    check("run_not_before_last_coef", pix_ready, 0);
                    exp_run = c + 1;
                end
            end
            if (c == exp_run) check("run_entry", pix_ready, 1);
            if (pi == gap_at && pix_ready && !pix_valid && abort_cyc < 0)
                check("dp_en_in_gap", dp_en, 0);
            if (pix_valid && pix_ready) begin
                check("dp_en_on_pixel", dp_en, 1);
                check("dp_x_pixel", dp_x, pix_data);
                if ((pi / IMG_W) >= FN - 1 && (pi % IMG_W) >= FN - 1)
                    out_q.push_back('{cyc: c + DP_LAT, last: (pi == NPIX - 1)});
                pi++;
                if (pi == NPIX) begin
                    last_acc = c;
                    exp_done = c + DP_LAT + 1;
                end
            end
            if (last_acc >= 0 && c > last_acc && c <= last_acc + DP_LAT) begin
                check("drain_dp_en", dp_en, 1);
                check("drain_dp_x", dp_x, 0);
                check("drain_pix_ready", pix_ready, 0);
                if (rst_drain) begin
                    resetn = 1'b0;
                    #1;
                    check("rst_outputs", {coef_ready, pix_ready, wr_en, dp_en, clip, relu,
                                          out_valid, out_last, busy, done}, 0);
                    check("rst_buses", {wr_addr, wr_data, dp_x, relu_c}, 0);
                    prune_out(c);
                    exp_done = -1;
                    @(posedge clk); #1;
                    resetn = 1'b1;
                    @(posedge clk); #1;
                    check("idle_after_rst", busy, 0);
                    check("no_done_after_rst", done_seen - done0, 0);
                    finished = 1;
                end
            end
            if (!finished && last_acc >= 0 && c == exp_done + 1) begin
                check("busy_low_after_done", busy, 0);
                check("one_done_pulse", done_seen - done0, 1);
                check("relu_c_held", relu_c, rc);
                finished = 1;
            end
            if (!finished && abort_cyc >= 0 && c == abort_cyc + 1) begin
                check("abort_idle", busy, 0);
                check("abort_pix_ready", pix_ready, 0);
                repeat (6) @(posedge clk);
                #1;
                check("abort_no_done", done_seen - done0, 0);
                check("abort_cfg_kept", relu_c, rc);
                finished = 1;
            end
        end
        check("frame_finished", finished, 1);
        check("wr_q_drained", wr_q.size(), 0);
        check("out_q_drained", out_q.size(), 0);
        wr_q.delete();
        out_q.delete();
        coef_valid = 1'b0; pix_valid = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        wr_t  w;
        out_t o;
        fork
            forever begin
                @(negedge clk);
                if (resetn) begin
                    if (wr_en) begin
                        if (wr_q.size() == 0) check("wr_extra", wr_en, 0);
                        else begin
                            w = wr_q.pop_front();
                            check("wr_cycle", cyc, w.cyc);
                            check("wr_addr", wr_addr, w.addr);
                            check("wr_data", wr_data, w.data);
                        end
                    end
                    if (out_valid) begin
                        if (out_q.size() == 0) check("out_extra", out_valid, 0);
                        else begin
                            o = out_q.pop_front();
                            check("out_cycle", cyc, o.cyc);
                            check("out_last", out_last, o.last);
                        end
                    end else if (out_last) begin
                        check("out_last_stray", out_last, 0);
                    end
                    if (done) begin
                        done_seen++;
                        check("done_cycle", cyc, exp_done);
                    end
                end
            end
        join_none

        #1;
        check("reset_outputs", {coef_ready, pix_ready, wr_en, dp_en, clip, relu,
                                out_valid, out_last, busy, done}, 0);
        check("reset_buses", {wr_addr, wr_data, dp_x, relu_c}, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {coef_ready, pix_ready, busy}, 0);

        run_frame(1'b0, -1, -1, 1'b0, 1'b0, 8'h12);   // continuous streams
        run_frame(1'b1, -1, -1, 1'b0, 1'b0, 8'h21);   // coef_valid every other cycle
        run_frame(1'b0,  9, -1, 1'b1, 1'b0, 8'h3C);   // pixel gap + ignored start
        run_frame(1'b0, -1, 12, 1'b0, 1'b0, 8'h47);   // abort after pixel 11
        run_frame(1'b0, -1, -1, 1'b0, 1'b0, 8'h5A);   // full frame after abort

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; cfg_relu_c = 8'h99;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; cfg_relu_c = 8'h00;
        #1;
        check("abort_beats_start", busy, 0);
        check("abort_start_cfg", relu_c, 8'h5A);

        run_frame(1'b0, -1, -1, 1'b0, 1'b1, 8'h63);   // reset during drain

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
